dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Shares the single-ported synchronous data memory between two requesters: the CPU load/store path (whose byte enables and lane-aligned write data come from the store-lane formatting logic) and a secondary DMA/loader port. Each cycle it grants at most one access. The CPU has priority, bounded by a starvation counter, and the DMA port can lock the memory for bursts. Read data is routed back to the owner with fixed one-cycle latency.

## Interface
Parameters:
- ADDR_W, 14 — memory word-address width; byte address bits [ADDR_W+1:2] select the word.
- STARVE_MAX, 4 — consecutive denied DMA cycles after which DMA wins; range 1..15.

Ports:
- clk  in  1  — single clock.
- rst  in  1  — reset, asynchronous, active-high.
- cpu_req_valid  in  1  — CPU access request.
- cpu_req_ready  out  1  — CPU request accepted this cycle.
- cpu_addr  in  32  — CPU byte address.
- cpu_we  in  4  — CPU byte write enables; 0000 means a read.
- cpu_wdata  in  32  — CPU lane-aligned write data.
- cpu_rdata  out  32  — CPU read data.
- cpu_rvalid  out  1  — cpu_rdata valid.
- dma_req_valid, dma_req_ready, dma_addr, dma_we, dma_wdata, dma_rdata, dma_rvalid — same widths and meaning as the CPU ports, for the DMA requester.
- dma_lock  in  1  — DMA requests exclusive ownership while high.
- mem_en  out  1  — memory access strobe.
- mem_we  out  4  — memory byte write enables.
- mem_addr  out  ADDR_W  — memory word address.
- mem_wdata  out  32  — memory write data.
- mem_rdata  in  32  — memory read data; valid one cycle after a read strobe.

## Operation
- Handshake: a request is accepted in any cycle where valid and ready are both 1. The requester holds addr, we and wdata stable while valid=1 and ready=0.
- Grant: each cycle, at most one of cpu_req_ready and dma_req_ready is 1. Ready is combinational from valid and state, and is 0 when the matching valid is 0.
- Priority in IDLE:
  - If starve_cnt == STARVE_MAX and dma_req_valid, DMA wins.
  - Otherwise, if cpu_req_valid, CPU wins.
  - Otherwise, if dma_req_valid, DMA wins.
- Memory drive on an accepted request: mem_en=1; mem_we, mem_addr and mem_wdata come from the winner. mem_addr = addr[ADDR_W+1:2]. With no accept: mem_en=0, mem_we=0000, mem_addr=0, mem_wdata=0.
- starve_cnt (4 bits):
  - Cleared when DMA is accepted or dma_req_valid=0.
  - Otherwise incremented when dma_req_valid=1 and CPU is accepted.
  - Saturates at STARVE_MAX.
  - Holds in all other cases.
- States:
  - IDLE: normal arbitration. IDLE→LOCKED when DMA is accepted with dma_lock=1.
  - LOCKED: cpu_req_ready=0; DMA is granted whenever dma_req_valid=1. LOCKED→IDLE on the clock edge where dma_lock=0 is sampled; normal arbitration resumes on the following cycle. An access accepted in that final LOCKED cycle completes normally. starve_cnt holds at 0 throughout LOCKED.
- Read return: an accepted read (we=0000) sets a registered owner tag (rd_pend, rd_owner). In the next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other port's rvalid=0 and its rdata=0.
- Writes produce no response.
- Back-to-back accepts are legal every cycle, in any order of owners.

## Timing
- Accept to memory strobe: 0 cycles, combinational.
- Read accept to rvalid: exactly 1 cycle. rvalid is a single-cycle pulse per read.
- Throughput: 1 access per cycle.
- Reset (asynchronous, active-high):
  - State = IDLE, starve_cnt=0, rd_pend=0, cpu_rvalid=0, dma_rvalid=0, rdata outputs=0.
  - While rst=1, both readies=0 and mem_en=0.
- Reset mid-read: a pending read is dropped and no rvalid is produced after reset.
- Reset during LOCKED returns to IDLE.
- Simultaneous events:
  - Both ports valid in the same cycle: resolved by the priority rules above.
  - dma_lock rising with no DMA accept does not lock.
  - A CPU read returning while a DMA read is accepted in the same cycle is legal, since the tag is registered per cycle.

## Test plan
- Idle CPU read only, addr=0x0000_0010, memory word 4 = 0xDEADBEEF → cpu_req_ready=1 and mem_en=1 with mem_addr=4 in cycle N; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in N+1; dma_rvalid=0.
- Both ports valid continuously with STARVE_MAX=4 → CPU accepted 4 cycles, DMA accepted in cycle 5, then the pattern repeats with a period of 5.
- CPU sb: we=0100, wdata=0x00AB_0000 at addr 0x6, concurrent DMA read → in cycle 0 mem_we=0100, mem_addr=1, and DMA stalls; in cycle 1 DMA is accepted; in cycle 2 dma_rvalid=1.
- DMA accepted with dma_lock=1 for 3 cycles, CPU valid throughout → cpu_req_ready=0 until the cycle after dma_lock falls, then the CPU is accepted.
- Alternating CPU read / DMA read every cycle → each rvalid goes to the correct owner 1 cycle after its accept, with no cross-routing.
- Assert rst in the cycle after a CPU read accept → cpu_rvalid stays 0, and all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares one single-ported synchronous data memory between the CPU
// load/store path and a secondary DMA/loader port. At most one access is
// granted per cycle. The CPU normally wins, but a starvation counter
// guarantees the DMA port a slot after STARVE_MAX consecutive denied cycles.
// The DMA port can also lock the memory for bursts. Read data is steered
// back to whichever port issued the read, exactly one cycle after accept.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_req_valid / cpu_req_ready  CPU request handshake
//   cpu_addr, cpu_we, cpu_wdata    CPU byte address, byte enables (0 = read),
//                                  lane-aligned write data
//   cpu_rdata / cpu_rvalid         CPU read return
//   dma_*                          same set for the DMA requester
//   dma_lock                       DMA asks for exclusive ownership
//   mem_en, mem_we, mem_addr,
//   mem_wdata                      memory access strobe and write payload
//   mem_rdata                      memory read data, one cycle after a read

module dmem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,

  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic [31:0]       dma_addr,
  input  logic [3:0]        dma_we,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_rvalid,
  input  logic              dma_lock,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_next;
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;
  logic       cpu_win;
  logic       dma_win;
  logic       rd_pend;
  logic       rd_owner;

  // Byte-offset and above-window address bits never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              dma_addr[31:ADDR_W+2], dma_addr[1:0]};

  // Arbitration, lock tracking and starvation counting. Grants are gated by
  // rst so nothing can be accepted while reset is held.
  always_comb begin
    cpu_win     = 1'b0;
    dma_win     = 1'b0;
    state_next  = state;
    starve_next = starve_cnt;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (dma_req_valid && (starve_cnt == STARVE_LIM)) begin
            dma_win = 1'b1;
          end else if (cpu_req_valid) begin
            cpu_win = 1'b1;
          end else if (dma_req_valid) begin
            dma_win = 1'b1;
          end
          if (dma_win && dma_lock) begin
            state_next = LOCKED;
          end
          // Only a DMA that is actually waiting behind a CPU accept ages.
          if (dma_win || !dma_req_valid) begin
            starve_next = 4'd0;
          end else if (cpu_win && (starve_cnt != STARVE_LIM)) begin
            starve_next = starve_cnt + 4'd1;
          end
        end
        LOCKED: begin
          // The last locked cycle (dma_lock low) may still carry a DMA access.
          dma_win     = dma_req_valid;
          starve_next = 4'd0;
          if (!dma_lock) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign cpu_req_ready = cpu_win;
  assign dma_req_ready = dma_win;

  // Memory strobe and payload come straight from the winning port.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr[ADDR_W+1:2];
      mem_wdata = dma_wdata;
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Read owner tag: one entry is enough because the memory latency is a
  // fixed single cycle and the tag is rewritten every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= (cpu_win && (cpu_we == 4'b0000)) ||
                  (dma_win && (dma_we == 4'b0000));
      rd_owner <= dma_win;
    end
  end

  // Return path: only the owner sees data, the other port reads zero.
  assign cpu_rvalid = rd_pend && !rd_owner;
  assign dma_rvalid = rd_pend && rd_owner;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : 32'd0;

endmodule
